// File: rtl/da_bit_plane_gen.sv
// da_bit_plane_gen
//   Feeds the distributed-arithmetic LUT stage. Takes one K-element activation
//   vector and one K-element weight vector per transaction. It then streams the
//   activation bit-planes LSB first, one plane per cycle, in offset-binary form.
//   The weights are held on B_temp for the whole transaction.
//
// Ports
//   clk, rst          : clock; synchronous active-high reset
//   in_valid/in_ready : transaction handshake (a_in, b_in)
//   a_in [K][DW_A]    : activations, latched into per-lane shift registers
//   b_in [K][DW_B]    : weights, latched into B_temp
//   A0                : bit t of activation 0
//   addr_array [K-1]  : bit j-1 = a[j][t] ^ a[0][t]
//   B_temp [K][DW_B]  : latched weights
//   t                 : plane index (0 when idle)
//   gen_done          : plane outputs valid
//   last              : sign (MSB) plane; the consumer applies the negative weight
//   busy              : running a transaction

// One activation lane: loads a vector element, then shifts right once per plane.
module da_bp_lane #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         lsb
);
    logic [W-1:0] sreg;

    always_ff @(posedge clk) begin
        if (rst)        sreg <= '0;
        else if (load)  sreg <= d;
        else if (shift) sreg <= sreg >> 1;
    end

    assign lsb = sreg[0];
endmodule

module da_bit_plane_gen #(
    parameter int DATA_WIDTH_A = 16,
    parameter int DATA_WIDTH_B = 16,
    parameter int K            = 9
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [K-1:0][DATA_WIDTH_A-1:0]   a_in,
    input  logic [K-1:0][DATA_WIDTH_B-1:0]   b_in,
    output logic                             A0,
    output logic [K-2:0]                     addr_array,
    output logic [K-1:0][DATA_WIDTH_B-1:0]   B_temp,
    output logic [7:0]                       t,
    output logic                             gen_done,
    output logic                             last,
    output logic                             busy
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [7:0] T_LAST = 8'(DATA_WIDTH_A - 1);

    state_t       state, state_nx;
    logic [7:0]   t_q;
    logic         at_end;
    logic         load;
    logic [K-1:0] lsb;

    assign at_end = (t_q == T_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // The last plane doubles as the acceptance slot. This gives back-to-back
    // transactions with no bubble.
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        gen_done = 1'b0;
        busy     = 1'b0;
        load     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                gen_done = 1'b1;
                busy     = 1'b1;
                if (at_end) begin
                    in_ready = 1'b1;
                    if (in_valid) load = 1'b1;
                    else          state_nx = IDLE;
                end
            end
        endcase
    end

    // Wrap to 0 on the last plane so that IDLE always sees t_q == 0.
    always_ff @(posedge clk) begin
        if (rst || load)   t_q <= '0;
        else if (gen_done) t_q <= at_end ? 8'd0 : t_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)       B_temp <= '0;
        else if (load) B_temp <= b_in;
    end

    for (genvar i = 0; i < K; i++) begin : g_lane
        da_bp_lane #(.W(DATA_WIDTH_A)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .load  (load),
            .shift (gen_done),
            .d     (a_in[i]),
            .lsb   (lsb[i])
        );
    end

    // Plane encoding uses registered bits only. It is gated so that idle reads 0.
    assign A0 = gen_done & lsb[0];
    for (genvar j = 1; j < K; j++) begin : g_addr
        assign addr_array[j-1] = gen_done & (lsb[j] ^ lsb[0]);
    end

    assign t    = gen_done ? t_q : 8'd0;
    assign last = gen_done & at_end;
endmodule

// File: tb/tb_da_bit_plane_gen.sv
module tb_da_bit_plane_gen;
    localparam int DW = 16;
    localparam int BW = 16;
    localparam int K  = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, in_valid, in_ready, A0, gen_done, last, busy;
    logic [K-1:0][DW-1:0] a_in;
    logic [K-1:0][BW-1:0] b_in, B_temp;
    logic [K-2:0]         addr_array;
    logic [7:0]           t;

    da_bit_plane_gen #(.DATA_WIDTH_A(DW), .DATA_WIDTH_B(BW), .K(K)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .A0(A0), .addr_array(addr_array),
        .B_temp(B_temp), .t(t), .gen_done(gen_done), .last(last), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    task automatic chk(string nm, logic [159:0] act, logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: the current vectors plus which plane is showing.
    logic [K-1:0][DW-1:0] m_a = '0;
    logic [K-1:0][BW-1:0] m_b = '0;
    int                   m_pl = 0;
    bit                   m_act = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_act <= 0; m_pl <= 0; m_b <= '0;
        end else if (in_valid && (!m_act || m_pl == DW-1)) begin
            m_a <= a_in; m_b <= b_in; m_pl <= 0; m_act <= 1;
        end else if (m_act) begin
            if (m_pl == DW-1) m_act <= 0;
            else              m_pl <= m_pl + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [K-2:0] e_addr;
            logic         e_a0;
            e_a0   = m_act ? m_a[0][m_pl] : 1'b0;
            e_addr = '0;
            if (m_act)
                for (int j = 1; j < K; j++) e_addr[j-1] = m_a[j][m_pl] ^ m_a[0][m_pl];
            chk("gen_done", 160'(gen_done), 160'(m_act));
            chk("busy",     160'(busy),     160'(m_act));
            chk("in_ready", 160'(in_ready), 160'(!m_act || m_pl == DW-1));
            chk("last",     160'(last),     160'(m_act && m_pl == DW-1));
            chk("t",        160'(t),        160'(m_act ? m_pl : 0));
            chk("A0",       160'(A0),       160'(e_a0));
            chk("addr",     160'(addr_array), 160'(e_addr));
            chk("B_temp",   160'(B_temp),   160'(m_b));
        end
    end

    // Drive one vector and hold in_valid across one rising edge. Returns #1
    // after that edge.
    task automatic send(input logic [K-1:0][DW-1:0] a, input logic [K-1:0][BW-1:0] b);
        in_valid = 1; a_in = a; b_in = b;
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    logic [K-1:0][DW-1:0] va, vb;
    logic [K-1:0][BW-1:0] wa, wb;
    int cyc, pulses;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; in_valid = 0; a_in = '0; b_in = '0;
        tick(); chk_en = 1;
        tick();
        chk("rst_ready",  160'(in_ready), 160'(1));
        chk("rst_gd",     160'(gen_done), 160'(0));
        chk("rst_btemp",  160'(B_temp),   160'(0));
        chk("rst_t",      160'(t),        160'(0));
        rst = 0; tick();

        // 1: bit-0 pattern
        va = '0; wa = '0;
        for (int i = 1; i < K; i++) va[i] = 16'h0001;
        send(va, wa);
        cyc = 0;
        while (gen_done && cyc < 40) begin
            if (t == 0) chk("s1_addr_t0", 160'(addr_array), 160'(8'hFF));
            if (t == 3) chk("s1_addr_t3", 160'(addr_array), 160'(8'h00));
            if (t == 15) chk("s1_last", 160'(last), 160'(1));
            cyc++; tick();
        end
        chk("s1_len", 160'(cyc), 160'(16));
        chk("s1_ready", 160'(in_ready), 160'(1));

        // 2: sign/XOR pattern, weights 1..9
        va = '0; va[0] = 16'hFFFF;
        for (int i = 0; i < K; i++) wa[i] = 16'(i + 1);
        send(va, wa);
        cyc = 0;
        while (gen_done && cyc < 40) begin
            if (t == 9) begin
                chk("s2_a0",   160'(A0),         160'(1));
                chk("s2_addr", 160'(addr_array), 160'(8'hFF));
                chk("s2_b",    160'(B_temp),
                    160'({16'd9,16'd8,16'd7,16'd6,16'd5,16'd4,16'd3,16'd2,16'd1}));
            end
            cyc++; tick();
        end
        tick();
        chk("s2_b_idle", 160'(B_temp),
            160'({16'd9,16'd8,16'd7,16'd6,16'd5,16'd4,16'd3,16'd2,16'd1}));

        // 3: mixed pattern
        va = '0; va[0] = 16'h8001; va[1] = 16'h0003;
        send(va, wa);
        chk("s3_t0_a0", 160'(A0), 160'(1)); chk("s3_t0_addr", 160'(addr_array), 160'(8'hFE));
        tick();
        chk("s3_t1_a0", 160'(A0), 160'(0)); chk("s3_t1_addr", 160'(addr_array), 160'(8'h01));
        repeat (14) tick();
        chk("s3_t15", 160'(t), 160'(15));
        chk("s3_t15_a0", 160'(A0), 160'(1)); chk("s3_t15_addr", 160'(addr_array), 160'(8'hFF));
        chk("s3_t15_last", 160'(last), 160'(1));
        tick(); tick();

        // 4: back-to-back with in_valid held
        va = '0; va[2] = 16'h5A5A; wa = '0; wa[0] = 16'h1111;
        vb = '0; vb[5] = 16'hC3C3; wb = '0; wb[0] = 16'h2222;
        in_valid = 1; a_in = va; b_in = wa;
        tick();
        a_in = vb; b_in = wb;
        cyc = 0; pulses = 0;
        while (gen_done && cyc < 50) begin
            if (in_ready) pulses++;
            if (cyc == 15) chk("s4_b_old", 160'(B_temp), 160'(wa));
            if (cyc == 16) begin
                chk("s4_wrap_t", 160'(t), 160'(0));
                chk("s4_b_new",  160'(B_temp), 160'(wb));
            end
            cyc++; tick();
            if (cyc == 16) in_valid = 0;
        end
        chk("s4_len", 160'(cyc), 160'(32));
        chk("s4_pulses", 160'(pulses), 160'(2));
        tick();

        // 5: in_valid raised mid-run must be ignored
        va = '0; va[0] = 16'h1234; va[8] = 16'hF0F0; wa = '0; wa[3] = 16'h0777;
        vb = '1; wb = '1;
        send(va, wa);
        cyc = 0;
        while (gen_done && cyc < 40) begin
            if (t == 5) begin in_valid = 1; a_in = vb; b_in = wb; end
            if (t == 10) in_valid = 0;
            cyc++; tick();
        end
        chk("s5_len", 160'(cyc), 160'(16));
        chk("s5_b",   160'(B_temp), 160'(wa));
        chk("s5_busy", 160'(busy), 160'(0));

        // 6: reset at t=7 with in_valid high
        send(va, wa);
        repeat (7) tick();
        chk("s6_t7", 160'(t), 160'(7));
        rst = 1; in_valid = 1; a_in = vb; b_in = wb;
        tick();
        rst = 0; in_valid = 0;
        chk("s6_gd", 160'(gen_done), 160'(0));
        chk("s6_t", 160'(t), 160'(0));
        chk("s6_addr", 160'(addr_array), 160'(0));
        chk("s6_b", 160'(B_temp), 160'(0));
        tick();
        chk("s6_idle", 160'(gen_done), 160'(0));
        send(va, wa);
        chk("s6_restart_t", 160'(t), 160'(0));
        chk("s6_restart_gd", 160'(gen_done), 160'(1));
        repeat (20) tick();

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/da_bit_plane_gen.md
# da_bit_plane_gen

Upstream feeder for the distributed-arithmetic LUT stage. It accepts one K-element activation vector and one K-element weight vector per transaction, then streams the activation bit-planes LSB first, one plane per cycle. Each plane is emitted in offset-binary-coded form: an A0 bit, a K-1 bit XOR'd address, a plane index, and a valid strobe. The weights are held stable on the LUT's B_temp inputs for the whole transaction. Back-to-back transactions stream with no bubble cycles.

## Interface
Parameters:
- DATA_WIDTH_A, 16, activation width; also the number of bit-planes per transaction (2..256)
- DATA_WIDTH_B, 16, weight width
- K, 9, vector length (odd, ≥3)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  a_in/b_in hold a transaction
- in_ready  out  1  block can accept a transaction this cycle
- a_in  in  K x DATA_WIDTH_A signed  activations
- b_in  in  K x DATA_WIDTH_B signed  weights
- A0  out  1  bit t of activation 0
- addr_array  out  K-1  bit j-1 = a[j][t] XOR a[0][t], for j=1..K-1
- B_temp  out  K x DATA_WIDTH_B signed  latched weights
- t  out  8  current plane index
- gen_done  out  1  plane outputs valid this cycle
- last  out  1  gen_done && t==DATA_WIDTH_A-1; this is the sign (MSB) plane
- busy  out  1  state is RUN

## Operation
- States: IDLE and RUN.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a_in into K shift registers and b_in into the weight registers; set t=0; go to RUN.
- RUN:
  - gen_done=1.
  - Outputs are derived from bit 0 of each shift register. Every shift register shifts right by 1 each cycle. t increments by 1 each cycle.
- RUN with t==DATA_WIDTH_A-1:
  - last=1 and in_ready=1.
  - If in_valid: reload both vectors, set t=0, stay in RUN.
  - Otherwise: go to IDLE.
- In RUN with t<DATA_WIDTH_A-1: in_ready=0. in_valid is ignored, and a_in/b_in may change freely.
- While gen_done=0 (IDLE and reset):
  - A0=0, addr_array=0, t=0, last=0.
  - B_temp holds its last latched value. It reads 0 after reset.
- Plane encoding: A0 and addr_array are combinational XORs of registered shift-register bits only. No input feeds them combinationally.
- Sign handling: planes carry no weighting. The consumer applies the negative weight of the MSB plane using last.
- Width: t is zero-extended into 8 bits. DATA_WIDTH_A must be ≤256.
- Reset in RUN:
  - Abort immediately to IDLE with all outputs at reset values. No partial-plane output.
  - The next transaction restarts at t=0.
- in_valid and rst together: rst wins, nothing is latched.

## Timing
- Reset values:
  - in_ready=1 (IDLE).
  - gen_done=0, last=0, busy=0, A0=0, addr_array=0, t=0, B_temp=0.
- Acceptance at edge E: plane t=0 is valid from cycle E+1. Plane t=n is valid in cycle E+1+n.
- last is asserted in cycle E+DATA_WIDTH_A.
- A transaction occupies exactly DATA_WIDTH_A gen_done cycles.
- Back-to-back: acceptance on the last cycle puts plane 0 of the next transaction in the immediately following cycle. gen_done stays high, and t goes DATA_WIDTH_A-1 → 0.
- Throughput: one transaction per DATA_WIDTH_A cycles at full rate.
- B_temp changes only on an acceptance edge. It is stable for every gen_done cycle of that transaction.

## Test plan
All scenarios use K=9 and DATA_WIDTH_A=16.

1. Simple bit-0 pattern:
   - Stimulus: a[0]=0x0000, a[1..8]=0x0001.
   - Required: at t=0, A0=0 and addr_array=0xFF. At t=1..15, A0=0 and addr_array=0x00. last only at t=15. gen_done for exactly 16 cycles, then IDLE with in_ready=1.
2. Sign/XOR pattern:
   - Stimulus: a[0]=0xFFFF (-1), a[1..8]=0x0000, b[i]=i+1.
   - Required: A0=1 and addr_array=0xFF on all 16 planes. B_temp={1..9} throughout. B_temp is unchanged after return to IDLE.
3. Mixed pattern:
   - Stimulus: a[0]=0x8001, a[1]=0x0003, others 0.
   - Required:
     - t=0: A0=1, addr=0xFE.
     - t=1: A0=0, addr=0x01.
     - t=2..14: A0=0, addr=0x00.
     - t=15: A0=1, addr=0xFF, last=1.
4. Back-to-back:
   - Stimulus: hold in_valid=1 with two vectors.
   - Required: in_ready pulses only at t=15. Exactly 32 consecutive gen_done cycles with t wrapping 15→0. Second vector's B_temp appears on the cycle after the wrap edge.
5. Busy stall:
   - Stimulus: assert in_valid with a new vector at t=5 and drop it at t=10.
   - Required: no capture, planes unchanged, returns to IDLE after t=15.
6. Reset mid-run:
   - Stimulus: rst=1 for 1 cycle at t=7, with in_valid also high.
   - Required: next cycle gen_done=0, t=0, addr=0, B_temp=0, nothing latched. A fresh transaction then starts at t=0.
